// File: rtl/encoder_8b10b_tx_ctrl.sv
// 8b/10b transmit controller: byte handshake, sub-encoder steering, RD ownership and output register.
// Define TX_SKP_INSERT_EN to enable periodic SKP ordered-set insertion (COM + SKP_COUNT x SKP).
module encoder_8b10b_tx_ctrl #(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_COUNT    = 3,
  parameter int INIT_RD_NEG  = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] data_i,
  input  logic       is_k_i,
  output logic [4:0] enc5b6b_data_o,
  output logic       enc5b6b_rd_neg_o,
  input  logic [5:0] enc5b6b_sym_i,
  input  logic       enc5b6b_rd_neg_post_i,
  output logic [2:0] enc3b4b_data_o,
  output logic       enc3b4b_rd_neg_o,
  output logic       enc3b4b_is_k_o,
  input  logic [3:0] enc3b4b_sym_i,
  input  logic       enc3b4b_rd_neg_post_i,
  output logic       enc_is_k_o,
  output logic       sym_valid_o,
  input  logic       sym_ready_i,
  output logic [9:0] sym_o,
  output logic       rd_neg_o,
  output logic       skp_active_o
);

  localparam logic INIT_RD = (INIT_RD_NEG != 0);

  if (SKP_INTERVAL < 2 || SKP_COUNT < 1 || SKP_COUNT > 5) begin : g_param_check
    $error("encoder_8b10b_tx_ctrl: SKP_INTERVAL must be >= 2 and SKP_COUNT within 1..5");
  end

  logic       adv;
  logic       issue;
  logic [7:0] sel_byte;
  logic       sel_k;
  logic       rd_neg_q;

  // The output register may only be overwritten when empty or being drained this cycle.
  assign adv = ~sym_valid_o | sym_ready_i;

`ifdef TX_SKP_INSERT_EN
  typedef enum logic [1:0] {
    ST_DATA,
    ST_SKP_COM,
    ST_SKP_SYM
  } state_e;

  localparam int CNT_W = $clog2(SKP_INTERVAL + 1);
  localparam int IDX_W = (SKP_COUNT > 1) ? $clog2(SKP_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SKP_INTERVAL);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SKP_COUNT - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [IDX_W-1:0]   skp_idx_q, skp_idx_d;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= ST_DATA;
      sym_cnt_q <= '0;
      skp_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      sym_cnt_q <= sym_cnt_d;
      skp_idx_q <= skp_idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    sym_cnt_d    = sym_cnt_q;
    skp_idx_d    = skp_idx_q;
    in_ready_o   = 1'b0;
    issue        = 1'b0;
    sel_byte     = data_i;
    sel_k        = is_k_i;
    skp_active_o = 1'b0;
    unique case (state_q)
      ST_DATA: begin
        // A full interval holds off upstream; the ordered set starts on the next free slot.
        if (sym_cnt_q == CNT_MAX) begin
          if (adv) begin
            state_d   = ST_SKP_COM;
            sym_cnt_d = '0;
          end
        end else begin
          in_ready_o = adv;
          if (in_valid_i && adv) begin
            issue     = 1'b1;
            sym_cnt_d = sym_cnt_q + 1'b1;
          end
        end
      end
      ST_SKP_COM: begin
        sel_byte     = 8'hBC;
        sel_k        = 1'b1;
        skp_active_o = 1'b1;
        if (adv) begin
          issue     = 1'b1;
          skp_idx_d = '0;
          state_d   = ST_SKP_SYM;
        end
      end
      ST_SKP_SYM: begin
        sel_byte     = 8'h1C;
        sel_k        = 1'b1;
        skp_active_o = 1'b1;
        if (adv) begin
          issue = 1'b1;
          if (skp_idx_q == IDX_LAST) begin
            skp_idx_d = '0;
            state_d   = ST_DATA;
          end else begin
            skp_idx_d = skp_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_DATA;
    endcase
  end
`else
  always_comb begin
    in_ready_o = adv;
    issue      = in_valid_i & adv;
    sel_byte   = data_i;
    sel_k      = is_k_i;
  end

  assign skp_active_o = 1'b0;
`endif

  assign enc5b6b_data_o   = sel_byte[4:0];
  assign enc3b4b_data_o   = sel_byte[7:5];
  assign enc_is_k_o       = sel_k;
  assign enc3b4b_is_k_o   = sel_k;
  assign enc5b6b_rd_neg_o = rd_neg_q;
  assign enc3b4b_rd_neg_o = enc5b6b_rd_neg_post_i;
  assign rd_neg_o         = rd_neg_q;

  // RD only advances together with a committed symbol, so a stalled symbol keeps its disparity.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sym_valid_o <= 1'b0;
      sym_o       <= '0;
      rd_neg_q    <= INIT_RD;
    end else if (adv) begin
      if (issue) begin
        sym_o       <= {enc5b6b_sym_i, enc3b4b_sym_i};
        sym_valid_o <= 1'b1;
        rd_neg_q    <= enc3b4b_rd_neg_post_i;
      end else begin
        sym_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_encoder_8b10b_tx_ctrl.sv
// Self-checking bench for encoder_8b10b_tx_ctrl with behavioural 5b6b/3b4b sub-encoders.
// Runs the SKP insertion scenarios when TX_SKP_INSERT_EN is defined, the long data run otherwise.
module tb_encoder_8b10b_tx_ctrl;

  localparam int SKP_INT = 8;
  localparam int SKP_CNT = 3;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b0;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [7:0] data_i = 8'h00;
  logic       is_k_i = 1'b0;
  logic [4:0] enc5b6b_data_o;
  logic       enc5b6b_rd_neg_o;
  logic [5:0] enc5b6b_sym_i;
  logic       enc5b6b_rd_neg_post_i;
  logic [2:0] enc3b4b_data_o;
  logic       enc3b4b_rd_neg_o;
  logic       enc3b4b_is_k_o;
  logic [3:0] enc3b4b_sym_i;
  logic       enc3b4b_rd_neg_post_i;
  logic       enc_is_k_o;
  logic       sym_valid_o;
  logic       sym_ready_i = 1'b1;
  logic [9:0] sym_o;
  logic       rd_neg_o;
  logic       skp_active_o;

  always #5 clk_i = ~clk_i;

  encoder_8b10b_tx_ctrl #(
    .SKP_INTERVAL(SKP_INT),
    .SKP_COUNT   (SKP_CNT),
    .INIT_RD_NEG (1)
  ) dut (
    .clk_i                (clk_i),
    .reset_i              (reset_i),
    .in_valid_i           (in_valid_i),
    .in_ready_o           (in_ready_o),
    .data_i               (data_i),
    .is_k_i               (is_k_i),
    .enc5b6b_data_o       (enc5b6b_data_o),
    .enc5b6b_rd_neg_o     (enc5b6b_rd_neg_o),
    .enc5b6b_sym_i        (enc5b6b_sym_i),
    .enc5b6b_rd_neg_post_i(enc5b6b_rd_neg_post_i),
    .enc3b4b_data_o       (enc3b4b_data_o),
    .enc3b4b_rd_neg_o     (enc3b4b_rd_neg_o),
    .enc3b4b_is_k_o       (enc3b4b_is_k_o),
    .enc3b4b_sym_i        (enc3b4b_sym_i),
    .enc3b4b_rd_neg_post_i(enc3b4b_rd_neg_post_i),
    .enc_is_k_o           (enc_is_k_o),
    .sym_valid_o          (sym_valid_o),
    .sym_ready_i          (sym_ready_i),
    .sym_o                (sym_o),
    .rd_neg_o             (rd_neg_o),
    .skp_active_o         (skp_active_o)
  );

  // Returns {rd_neg_after, abcdei}; only K28 is supported as a control code.
  function automatic logic [6:0] enc6(input logic [4:0] x, input logic k, input logic rd_neg);
    logic [5:0] t;
    logic       unbal;
    case (x)
      5'd0:  t = 6'b100111;  5'd1:  t = 6'b011101;  5'd2:  t = 6'b101101;  5'd3:  t = 6'b110001;
      5'd4:  t = 6'b110101;  5'd5:  t = 6'b101001;  5'd6:  t = 6'b011001;  5'd7:  t = 6'b111000;
      5'd8:  t = 6'b111001;  5'd9:  t = 6'b100101;  5'd10: t = 6'b010101;  5'd11: t = 6'b110100;
      5'd12: t = 6'b001101;  5'd13: t = 6'b101100;  5'd14: t = 6'b011100;  5'd15: t = 6'b010111;
      5'd16: t = 6'b011011;  5'd17: t = 6'b100011;  5'd18: t = 6'b010011;  5'd19: t = 6'b110010;
      5'd20: t = 6'b001011;  5'd21: t = 6'b101010;  5'd22: t = 6'b011010;  5'd23: t = 6'b111010;
      5'd24: t = 6'b110011;  5'd25: t = 6'b100110;  5'd26: t = 6'b010110;  5'd27: t = 6'b110110;
      5'd28: t = 6'b001110;  5'd29: t = 6'b101110;  5'd30: t = 6'b011110;  default: t = 6'b101011;
    endcase
    if (k) t = 6'b001111;
    unbal = ($countones(t) != 3);
    if (!rd_neg && (unbal || (x == 5'd7 && !k))) t = ~t;
    return {unbal ? ~rd_neg : rd_neg, t};
  endfunction

  // Returns {rd_neg_after, fghj}; x selects the alternate D.x.7 encoding.
  function automatic logic [4:0] enc4(input logic [2:0] y, input logic [4:0] x, input logic k,
                                      input logic rd_neg);
    logic [3:0] t;
    logic       unbal;
    logic       alt;
    alt = k || (rd_neg && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
          (!rd_neg && (x == 5'd11 || x == 5'd13 || x == 5'd14));
    case (y)
      3'd0: t = 4'b1011;  3'd1: t = 4'b1001;  3'd2: t = 4'b0101;  3'd3: t = 4'b1100;
      3'd4: t = 4'b1101;  3'd5: t = 4'b1010;  3'd6: t = 4'b0110;
      default: t = alt ? 4'b0111 : 4'b1110;
    endcase
    unbal = ($countones(t) != 2);
    if (!rd_neg && (unbal || y == 3'd3)) t = ~t;
    if (k && rd_neg && !unbal && y != 3'd3) t = ~t;
    return {unbal ? ~rd_neg : rd_neg, t};
  endfunction

  function automatic logic [10:0] encode10(input logic [7:0] b, input logic k, input logic rd_neg);
    logic [6:0] r6;
    logic [4:0] r4;
    r6 = enc6(b[4:0], k, rd_neg);
    r4 = enc4(b[7:5], b[4:0], k, r6[6]);
    return {r4[4], r6[5:0], r4[3:0]};
  endfunction

  function automatic bit is_comma(input logic [9:0] s);
    return (s == 10'b0011111010) || (s == 10'b1100000101) ||
           (s == 10'b0011110100) || (s == 10'b1100001011);
  endfunction

  always_comb begin
    {enc5b6b_rd_neg_post_i, enc5b6b_sym_i} = enc6(enc5b6b_data_o, enc_is_k_o, enc5b6b_rd_neg_o);
    {enc3b4b_rd_neg_post_i, enc3b4b_sym_i} =
      enc4(enc3b4b_data_o, enc5b6b_data_o, enc3b4b_is_k_o, enc3b4b_rd_neg_o);
  end

  typedef struct {
    logic [9:0] sym;
    logic       rd;
  } exp_t;

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       k;
    logic [9:0] sym;
    logic       rd;
  } vec_t;

  exp_t       exp_q[$];
  vec_t       tbl[8];
  int         checks = 0;
  int         failures = 0;
  logic       model_rd = 1'b1;
  int         accepted = 0;
  bit         prev_xfer = 1'b0;
  bit         last_xfer = 1'b0;
  int         skp_cycles = 0;
  int         kcode_seen = 0;
  int         ready_low = 0;
  logic [7:0] rnd_byte;
  logic       rnd_k;
  logic       rnd_v;
  logic       rnd_r;
  int         rnd_sel;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_model(input logic [7:0] b, input logic k);
    logic [10:0] e;
    e = encode10(b, k, model_rd);
    exp_q.push_back('{sym: e[9:0], rd: e[10]});
    model_rd = e[10];
  endtask

  // Drives one cycle from a falling edge: sample, score, then advance to the next falling edge.
  task automatic apply_stimulus(input logic [7:0] d, input logic k, input logic v, input logic r,
                                input bit use_model);
    exp_t e;
    data_i      = d;
    is_k_i      = k;
    in_valid_i  = v;
    sym_ready_i = r;
    #1;
    if (prev_xfer) check_output("latency_valid", sym_valid_o, 1);
    last_xfer = in_valid_i && in_ready_o;
    if (skp_active_o) begin
      check_output("skp_in_ready", in_ready_o, 0);
      if (!sym_valid_o || sym_ready_i) skp_cycles++;
    end
    if (sym_ready_i && !in_ready_o) ready_low++;
    if (sym_valid_o && is_comma(sym_o)) kcode_seen++;
    if (sym_valid_o && sym_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_sym: got 0x%0h, expected no symbol", sym_o);
      end else begin
        e = exp_q.pop_front();
        check_output("sym", sym_o, e.sym);
        check_output("rd_neg", rd_neg_o, e.rd);
      end
    end
    if (last_xfer) begin
      if (use_model) push_model(d, k);
      accepted++;
`ifdef TX_SKP_INSERT_EN
      if (accepted == SKP_INT) begin
        accepted = 0;
        push_model(8'hBC, 1'b1);
        for (int i = 0; i < SKP_CNT; i++) push_model(8'h1C, 1'b1);
      end
`endif
    end
    prev_xfer = last_xfer;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic apply_reset(input string tag);
    reset_i    = 1'b0;
    in_valid_i = 1'b0;
    #1;
    check_output({tag, "_valid"}, sym_valid_o, 0);
    check_output({tag, "_sym"}, sym_o, 0);
    check_output({tag, "_skp_active"}, skp_active_o, 0);
    @(negedge clk_i);
    reset_i = 1'b1;
    exp_q.delete();
    model_rd  = 1'b1;
    accepted  = 0;
    prev_xfer = 1'b0;
    #1;
    check_output({tag, "_rd_init"}, rd_neg_o, 1);
    @(negedge clk_i);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    check_output("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0] = '{"K28.5_rdn", 8'hBC, 1'b1, 10'b0011111010, 1'b0};
    tbl[1] = '{"K28.5_rdp", 8'hBC, 1'b1, 10'b1100000101, 1'b1};
    tbl[2] = '{"D0.0",      8'h00, 1'b0, 10'b1001110100, 1'b1};
    tbl[3] = '{"D21.5",     8'hB5, 1'b0, 10'b1010101010, 1'b1};
    tbl[4] = '{"D3.3",      8'h63, 1'b0, 10'b1100011100, 1'b1};
    tbl[5] = '{"D7.0_rdn",  8'h07, 1'b0, 10'b1110001011, 1'b0};
    tbl[6] = '{"D7.0_rdp",  8'h07, 1'b0, 10'b0001110100, 1'b1};
    tbl[7] = '{"D17.7_alt", 8'hF1, 1'b0, 10'b1000110111, 1'b0};

    apply_reset("init");
    #1;
    check_output("init_in_ready", in_ready_o, 1);
    @(negedge clk_i);

    // Known-answer vectors, one byte per cycle from reset RD-.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{sym: tbl[i].sym, rd: tbl[i].rd});
      model_rd = tbl[i].rd;
      apply_stimulus(tbl[i].data, tbl[i].k, 1'b1, 1'b1, 1'b0);
      check_output({"accept_", tbl[i].name}, last_xfer, 1);
    end
    drain();

    // Backpressure: symbol and RD frozen, upstream blocked, released byte taken immediately.
    apply_reset("stall");
    apply_stimulus(8'hBC, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      sym_ready_i = 1'b0;
      in_valid_i  = 1'b1;
      #1;
      check_output("stall_in_ready", in_ready_o, 0);
      check_output("stall_sym", sym_o, exp_q[0].sym);
      check_output("stall_rd", rd_neg_o, exp_q[0].rd);
      apply_stimulus(8'h4A, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    sym_ready_i = 1'b1;
    #1;
    check_output("release_in_ready", in_ready_o, 1);
    apply_stimulus(8'h4A, 1'b0, 1'b1, 1'b1, 1'b1);
    check_output("release_accept", last_xfer, 1);
    drain();

    // Reset while a symbol with positive RD is sitting in the output register.
    apply_reset("pre_mid");
    apply_stimulus(8'hBC, 1'b1, 1'b1, 1'b1, 1'b1);
    apply_reset("mid_traffic");

`ifdef TX_SKP_INSERT_EN
    // Eight D0.0 bytes trigger one full ordered set, then data resumes.
    skp_cycles = 0;
    for (int i = 0; i < 8 + 6; i++) apply_stimulus(8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    drain();
    check_output("skp_issue_cycles", skp_cycles, SKP_CNT + 1);

    // Reset after COM and the first SKP: the ordered set is abandoned.
    apply_reset("pre_skp_abort");
    skp_cycles = 0;
    for (int i = 0; i < 8; i++) apply_stimulus(8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 20 && skp_cycles < 2; i++) apply_stimulus(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    check_output("reach_skp_idx1", skp_cycles, 2);
    apply_reset("skp_abort");
    check_output("post_reset_skp_active", skp_active_o, 0);
    apply_stimulus(8'h4A, 1'b0, 1'b1, 1'b1, 1'b1);
    check_output("post_reset_skp_active2", skp_active_o, 0);
    drain();
`endif

    // Random traffic with random upstream valid and downstream backpressure.
    apply_reset("random");
    for (int i = 0; i < 300; i++) begin
      rnd_sel = $urandom_range(0, 9);
      rnd_v   = ($urandom_range(0, 3) != 0);
      rnd_r   = ($urandom_range(0, 3) != 0);
      if (rnd_sel == 0) begin
        rnd_byte = 8'hBC;
        rnd_k    = 1'b1;
      end else if (rnd_sel == 1) begin
        rnd_byte = 8'h1C;
        rnd_k    = 1'b1;
      end else begin
        rnd_byte = 8'($urandom);
        rnd_k    = 1'b0;
      end
      apply_stimulus(rnd_byte, rnd_k, rnd_v, rnd_r, 1'b1);
    end
    drain();

`ifndef TX_SKP_INSERT_EN
    // Long data-only run: no control codes appear and upstream is never throttled.
    apply_reset("long_run");
    kcode_seen = 0;
    ready_low  = 0;
    for (int i = 0; i < 2000; i++) begin
      rnd_byte = 8'($urandom);
      apply_stimulus(rnd_byte, 1'b0, 1'b1, 1'b1, 1'b1);
    end
    drain();
    check_output("long_no_kcode", kcode_seen, 0);
    check_output("long_ready_low", ready_low, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
